floo_vc_out_alloc: RTL and testbench

FLOO_VC_OUT_ALLOC -- requirements
Module: floo_vc_out_alloc

---
 rtl/floo_vc_out_alloc.sv | 157 +++++++++++++++
 tb/tb_floo_vc_out_alloc.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_vc_out_alloc.sv
// Output-port VC allocator: round-robin arbitration over input ports with
// per-VC credit tracking and packet-level (wormhole) locking.
module floo_vc_out_alloc #(
    parameter int unsigned NumReq      = 5,
    parameter int unsigned NumVC       = 4,
    parameter int unsigned VcIdWidth   = 2,
    parameter int unsigned CreditDepth = 3,
    parameter int unsigned FallbackEn  = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [NumReq-1:0]                  req_v_i,
    input  logic [NumReq-1:0][VcIdWidth-1:0]   req_vc_i,
    input  logic [NumReq-1:0]                  req_last_i,
    output logic [NumReq-1:0]                  gnt_o,
    output logic                               out_v_o,
    output logic [VcIdWidth-1:0]               out_vc_o,
    input  logic                               credit_v_i,
    input  logic [VcIdWidth-1:0]               credit_id_i,
    output logic                               credit_err_o
);

    localparam int unsigned IdxW      = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [0:0]  StIdle    = 1'b0;
    localparam logic [0:0]  StLocked  = 1'b1;
    localparam logic [2:0]  CreditMax = 3'(CreditDepth);

    logic [NumVC-1:0][2:0]  credit_q, credit_d;
    logic [0:0]             state_q, state_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic [IdxW-1:0]        lock_idx_q, lock_idx_d;
    logic [VcIdWidth-1:0]   lock_vc_q, lock_vc_d;
    logic                   credit_err_q, credit_err_d;

    logic [NumVC-1:0]       has_credit;
    logic                   any_credit;
    logic [VcIdWidth-1:0]   low_vc;
    logic                   xfer;
    logic [IdxW-1:0]        gnt_idx;
    logic [VcIdWidth-1:0]   sel_vc;
    logic [NumReq-1:0]      gnt;

    // VC identifiers beyond NumVC never have credit.
    function automatic logic vc_has_credit(input logic [VcIdWidth-1:0] vc,
                                           input logic [NumVC-1:0]     hc);
        vc_has_credit = 1'b0;
        for (int v = 0; v < int'(NumVC); v++) begin
            if (vc == VcIdWidth'(v)) vc_has_credit = hc[v];
        end
    endfunction

    always_comb begin
        has_credit = '0;
        any_credit = 1'b0;
        low_vc     = '0;
        for (int v = int'(NumVC) - 1; v >= 0; v--) begin
            has_credit[v] = (credit_q[v] != 3'd0);
            if (has_credit[v]) begin
                any_credit = 1'b1;
                low_vc     = VcIdWidth'(v);
            end
        end
    end

    always_comb begin
        logic [IdxW-1:0] idx;
        logic            pref_ok;
        idx     = '0;
        pref_ok = 1'b0;
        xfer    = 1'b0;
        gnt_idx = '0;
        sel_vc  = '0;
        gnt     = '0;
        if (!rst_i) begin
            if (state_q == StLocked) begin
                if (req_v_i[lock_idx_q] && vc_has_credit(lock_vc_q, has_credit)) begin
                    xfer    = 1'b1;
                    gnt_idx = lock_idx_q;
                    sel_vc  = lock_vc_q;
                end
            end else begin
                for (int k = 0; k < int'(NumReq); k++) begin
                    idx     = IdxW'((int'(ptr_q) + k) % int'(NumReq));
                    pref_ok = vc_has_credit(req_vc_i[idx], has_credit);
                    if (!xfer && req_v_i[idx] &&
                        (pref_ok || ((FallbackEn != 0) && any_credit))) begin
                        xfer    = 1'b1;
                        gnt_idx = idx;
                        sel_vc  = pref_ok ? req_vc_i[idx] : low_vc;
                    end
                end
            end
            if (xfer) gnt[gnt_idx] = 1'b1;
        end
    end

    assign gnt_o        = gnt;
    assign out_v_o      = xfer;
    assign out_vc_o     = sel_vc;
    assign credit_err_o = credit_err_q;

    // A transfer and a credit on the same VC cancel; an overflowing credit is dropped.
    always_comb begin
        logic dec, inc;
        dec          = 1'b0;
        inc          = 1'b0;
        credit_d     = credit_q;
        credit_err_d = 1'b0;
        for (int v = 0; v < int'(NumVC); v++) begin
            dec = xfer && (sel_vc == VcIdWidth'(v));
            inc = credit_v_i && (credit_id_i == VcIdWidth'(v));
            if (inc && !dec && (credit_q[v] == CreditMax)) begin
                inc          = 1'b0;
                credit_err_d = 1'b1;
            end
            if (inc && !dec)      credit_d[v] = credit_q[v] + 3'd1;
            else if (dec && !inc) credit_d[v] = credit_q[v] - 3'd1;
        end
        if (credit_v_i && (int'(credit_id_i) >= int'(NumVC))) credit_err_d = 1'b1;
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        lock_idx_d = lock_idx_q;
        lock_vc_d  = lock_vc_q;
        if (xfer) begin
            if (req_last_i[gnt_idx]) begin
                state_d = StIdle;
                ptr_d   = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
            end else if (state_q == StIdle) begin
                state_d    = StLocked;
                lock_idx_d = gnt_idx;
                lock_vc_d  = sel_vc;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            credit_q     <= {NumVC{CreditMax}};
            state_q      <= StIdle;
            ptr_q        <= '0;
            lock_idx_q   <= '0;
            lock_vc_q    <= '0;
            credit_err_q <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            lock_idx_q   <= lock_idx_d;
            lock_vc_q    <= lock_vc_d;
            credit_err_q <= credit_err_d;
        end
    end

endmodule

// File: tb/tb_floo_vc_out_alloc.sv
// Scoreboard bench for floo_vc_out_alloc: a default instance plus a
// 3-bit-VC-id, no-fallback instance for out-of-range credits and strict VCs.
module tb_floo_vc_out_alloc;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [4:0]      reqV;
    logic [4:0][1:0] reqVc;
    logic [4:0]      reqLast;
    logic            creditV;
    logic [1:0]      creditId;
    logic [4:0]      gnt;
    logic            outV;
    logic [1:0]      outVc;
    logic            creditErr;

    logic            rstB;
    logic [4:0]      reqVB;
    logic [4:0][2:0] reqVcB;
    logic [4:0]      reqLastB;
    logic            creditVB;
    logic [2:0]      creditIdB;
    logic [4:0]      gntB;
    logic            outVB;
    logic [2:0]      outVcB;
    logic            creditErrB;

    int checks   = 0;
    int failures = 0;

    // Expected {gnt, out_v, out_vc} per driven cycle.
    logic [7:0] expQ[$];
    logic [8:0] expQB[$];

    floo_vc_out_alloc dut (
        .clk_i(clk), .rst_i(rst),
        .req_v_i(reqV), .req_vc_i(reqVc), .req_last_i(reqLast),
        .gnt_o(gnt), .out_v_o(outV), .out_vc_o(outVc),
        .credit_v_i(creditV), .credit_id_i(creditId), .credit_err_o(creditErr)
    );

    floo_vc_out_alloc #(
        .NumReq(5), .NumVC(4), .VcIdWidth(3), .CreditDepth(3), .FallbackEn(0)
    ) dutB (
        .clk_i(clk), .rst_i(rstB),
        .req_v_i(reqVB), .req_vc_i(reqVcB), .req_last_i(reqLastB),
        .gnt_o(gntB), .out_v_o(outVB), .out_vc_o(outVcB),
        .credit_v_i(creditVB), .credit_id_i(creditIdB), .credit_err_o(creditErrB)
    );

    task automatic applyStimulus(input logic r, input logic [4:0] v, input logic [9:0] vc,
                                 input logic [4:0] last, input logic cv, input logic [1:0] cid);
        @(negedge clk);
        rst = r; reqV = v; reqVc = vc; reqLast = last; creditV = cv; creditId = cid;
    endtask

    task automatic applyStimulusB(input logic r, input logic [4:0] v, input logic [14:0] vc,
                                  input logic [4:0] last, input logic cv, input logic [2:0] cid);
        @(negedge clk);
        rstB = r; reqVB = v; reqVcB = vc; reqLastB = last; creditVB = cv; creditIdB = cid;
    endtask

    task automatic test_reset();
        logic [7:0] e;
        logic [8:0] eb;
        applyStimulus(1'b1, 5'b11111, 10'h0, 5'b11111, 1'b1, 2'd0);
        applyStimulusB(1'b1, 5'b11111, 15'h0, 5'b11111, 1'b0, 3'd0);
        expQ.push_back(8'h00);
        expQB.push_back(9'h000);
        #1;
        e = expQ.pop_front();
        checks++;
        if ({gnt, outV, outVc} !== e) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b exp=%b", {gnt, outV, outVc}, e);
        end
        eb = expQB.pop_front();
        checks++;
        if ({gntB, outVB, outVcB} !== eb) begin
            failures++;
            $display("[TB] FAIL reset_outputs_b got=%b exp=%b", {gntB, outVB, outVcB}, eb);
        end
        checks++;
        if (creditErr !== 1'b0 || creditErrB !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_credit_err got=%b/%b exp=0/0", creditErr, creditErrB);
        end
    endtask

    // Drains every VC, then exercises credit-return latency and same-cycle cancel.
    task automatic test_credit_drain();
        logic [7:0] e;
        int cvT[7]  = '{0, 1, 0, 1, 1, 0, 0};
        int cidT[7] = '{0, 3, 0, 1, 1, 0, 0};
        int evT[7]  = '{0, 0, 1, 0, 1, 1, 0};
        int evcT[7] = '{0, 0, 3, 0, 1, 1, 0};
        applyStimulus(1'b1, 5'b0, 10'h0, 5'b0, 1'b0, 2'd0);
        for (int c = 0; c < 12; c++) begin
            applyStimulus(1'b0, 5'b00001, {8'h0, 2'(c / 3)}, 5'b11111, 1'b0, 2'd0);
            expQ.push_back({5'b00001, 1'b1, 2'(c / 3)});
            #1;
            e = expQ.pop_front();
            checks++;
            if ({gnt, outV, outVc} !== e) begin
                failures++;
                $display("[TB] FAIL drain c=%0d got=%b exp=%b", c, {gnt, outV, outVc}, e);
            end
        end
        for (int c = 0; c < 7; c++) begin
            applyStimulus(1'b0, 5'b00001, {8'h0, 2'd1}, 5'b11111, 1'(cvT[c]), 2'(cidT[c]));
            expQ.push_back({(evT[c] != 0) ? 5'b00001 : 5'b00000, 1'(evT[c]), 2'(evcT[c])});
            #1;
            e = expQ.pop_front();
            checks++;
            if ({gnt, outV, outVc} !== e) begin
                failures++;
                $display("[TB] FAIL credit_return c=%0d got=%b exp=%b", c, {gnt, outV, outVc}, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] e;
        logic [4:0] expG[4] = '{5'b00010, 5'b01000, 5'b00010, 5'b01000};
        logic [1:0] expVc[4] = '{2'd0, 2'd1, 2'd0, 2'd1};
        applyStimulus(1'b1, 5'b0, 10'h0, 5'b0, 1'b0, 2'd0);
        for (int c = 0; c < 4; c++) begin
            applyStimulus(1'b0, 5'b01010, {2'd0, 2'd1, 2'd0, 2'd0, 2'd0}, 5'b11111, 1'b0, 2'd0);
            expQ.push_back({expG[c], 1'b1, expVc[c]});
            #1;
            e = expQ.pop_front();
            checks++;
            if ({gnt, outV, outVc} !== e) begin
                failures++;
                $display("[TB] FAIL round_robin c=%0d got=%b exp=%b", c, {gnt, outV, outVc}, e);
            end
        end
    endtask

    // Multi-flit packet from req 2 with a bubble and a credit stall while req 0 waits.
    task automatic test_packet_lock();
        logic [7:0] e;
        logic [4:0] vT[9]   = '{5'b00010, 5'b00101, 5'b00101, 5'b00001, 5'b00101,
                                5'b00101, 5'b00101, 5'b00101, 5'b00001};
        int r2vcT[9]        = '{1, 1, 3, 3, 3, 3, 3, 3, 3};
        int r2lastT[9]      = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        int cvT[9]          = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
        logic [4:0] gT[9]   = '{5'b00010, 5'b00100, 5'b00100, 5'b00000, 5'b00100,
                                5'b00000, 5'b00000, 5'b00100, 5'b00001};
        int evcT[9]         = '{3, 1, 1, 0, 1, 0, 0, 1, 0};
        applyStimulus(1'b1, 5'b0, 10'h0, 5'b0, 1'b0, 2'd0);
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b0, vT[c], {2'd0, 2'd0, 2'(r2vcT[c]), 2'd3, 2'd0},
                          {2'b11, 1'(r2lastT[c]), 2'b11}, 1'(cvT[c]), 2'd1);
            expQ.push_back({gT[c], |gT[c], 2'(evcT[c])});
            #1;
            e = expQ.pop_front();
            checks++;
            if ({gnt, outV, outVc} !== e) begin
                failures++;
                $display("[TB] FAIL packet_lock c=%0d got=%b exp=%b", c, {gnt, outV, outVc}, e);
            end
        end
    endtask

    task automatic test_credit_err();
        logic [7:0] e;
        int rvT[6]   = '{0, 0, 1, 1, 1, 1};
        int cvT[6]   = '{1, 0, 0, 0, 0, 0};
        int errT[6]  = '{0, 1, 0, 0, 0, 0};
        int evcT[6]  = '{0, 0, 0, 0, 0, 1};
        applyStimulus(1'b1, 5'b0, 10'h0, 5'b0, 1'b0, 2'd0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b0, {4'b0, 1'(rvT[c])}, 10'h0, 5'b11111, 1'(cvT[c]), 2'd0);
            expQ.push_back({4'b0, 1'(rvT[c]), 1'(rvT[c]), 2'(evcT[c])});
            #1;
            e = expQ.pop_front();
            checks++;
            if ({gnt, outV, outVc} !== e) begin
                failures++;
                $display("[TB] FAIL credit_full c=%0d got=%b exp=%b", c, {gnt, outV, outVc}, e);
            end
            checks++;
            if (creditErr !== 1'(errT[c])) begin
                failures++;
                $display("[TB] FAIL credit_err c=%0d got=%b exp=%0d", c, creditErr, errT[c]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] e;
        int rT[6]         = '{0, 1, 0, 0, 0, 0};
        logic [4:0] vT[6] = '{5'b00010, 5'b00011, 5'b00011, 5'b00001, 5'b00001, 5'b00001};
        logic [4:0] gT[6] = '{5'b00010, 5'b00000, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
        int evcT[6]       = '{0, 0, 0, 0, 0, 1};
        applyStimulus(1'b1, 5'b0, 10'h0, 5'b0, 1'b0, 2'd0);
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'(rT[c]), vT[c], 10'h0, 5'b11101, 1'b0, 2'd0);
            expQ.push_back({gT[c], |gT[c], 2'(evcT[c])});
            #1;
            e = expQ.pop_front();
            checks++;
            if ({gnt, outV, outVc} !== e) begin
                failures++;
                $display("[TB] FAIL mid_reset c=%0d got=%b exp=%b", c, {gnt, outV, outVc}, e);
            end
            checks++;
            if (creditErr !== 1'b0) begin
                failures++;
                $display("[TB] FAIL mid_reset_err c=%0d got=%b exp=0", c, creditErr);
            end
        end
    endtask

    // Strict-VC instance: no fallback once VC 2 drains; out-of-range credit id flags an error.
    task automatic test_no_fallback();
        logic [8:0] e;
        int rvT[7]  = '{1, 1, 1, 1, 0, 0, 1};
        int cvT[7]  = '{0, 0, 0, 0, 1, 1, 0};
        int cidT[7] = '{0, 0, 0, 0, 5, 2, 0};
        int gvT[7]  = '{1, 1, 1, 0, 0, 0, 1};
        int errT[7] = '{0, 0, 0, 0, 0, 1, 0};
        applyStimulusB(1'b1, 5'b0, 15'h0, 5'b0, 1'b0, 3'd0);
        for (int c = 0; c < 7; c++) begin
            applyStimulusB(1'b0, {4'b0, 1'(rvT[c])}, {12'h0, 3'd2}, 5'b11111,
                           1'(cvT[c]), 3'(cidT[c]));
            expQB.push_back({4'b0, 1'(gvT[c]), 1'(gvT[c]), (gvT[c] != 0) ? 3'd2 : 3'd0});
            #1;
            e = expQB.pop_front();
            checks++;
            if ({gntB, outVB, outVcB} !== e) begin
                failures++;
                $display("[TB] FAIL no_fallback c=%0d got=%b exp=%b", c, {gntB, outVB, outVcB}, e);
            end
            checks++;
            if (creditErrB !== 1'(errT[c])) begin
                failures++;
                $display("[TB] FAIL bad_credit_id c=%0d got=%b exp=%0d", c, creditErrB, errT[c]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; reqV = '0; reqVc = '0; reqLast = '0; creditV = 1'b0; creditId = '0;
        rstB = 1'b1; reqVB = '0; reqVcB = '0; reqLastB = '0; creditVB = 1'b0; creditIdB = '0;
        test_reset();
        test_credit_drain();
        test_round_robin();
        test_packet_lock();
        test_credit_err();
        test_reset_mid_packet();
        test_no_fallback();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
